bimodal_predictor: RTL and testbench

- Table of 2^INDEX_WIDTH saturating counters, each behaving as an independent up/down counter clamped to [0, COUNTER_RANGE-1].
- Produces a registered taken/not-taken prediction per lookup.
- Trains the indexed counter on each resolved outcome.
- Sits downstream of the fetch/PC-hash stage and upstream of the branch-resolution feedback path; the standard consumer of the team's saturating-counter primitive.

---
 rtl/bimodal_predictor.sv | 101 ++++++++++
 tb/tb_bimodal_predictor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bimodal_predictor.sv
// Bimodal branch predictor: a table of saturating counters with registered lookup and per-cycle training.
// Optional same-cycle forwarding of update/clear into the lookup result: define BIMODAL_PREDICTOR_BYPASS_EN.
module bimodal_predictor #(
  parameter int INDEX_WIDTH   = 6,
  parameter int COUNTER_RANGE = 4,
  parameter int RESET_VALUE   = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   lookup_valid,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  output logic                   prediction_valid,
  output logic                   prediction_taken,
  output logic                   prediction_strong,
  input  logic                   update_valid,
  input  logic [INDEX_WIDTH-1:0] update_index,
  input  logic                   update_taken
);

  localparam int ENTRIES       = 1 << INDEX_WIDTH;
  localparam int COUNTER_WIDTH = (COUNTER_RANGE <= 2) ? 1 : $clog2(COUNTER_RANGE);

  localparam logic [COUNTER_WIDTH-1:0] MAX_C    = COUNTER_WIDTH'(COUNTER_RANGE - 1);
  localparam logic [COUNTER_WIDTH-1:0] THRESH_C = COUNTER_WIDTH'(COUNTER_RANGE / 2);
  localparam logic [COUNTER_WIDTH-1:0] RESET_C  = COUNTER_WIDTH'(RESET_VALUE);

  logic [COUNTER_WIDTH-1:0] table_q [ENTRIES];

  logic [COUNTER_WIDTH-1:0] upd_cur;
  logic [COUNTER_WIDTH-1:0] upd_new;
  logic [COUNTER_WIDTH-1:0] rd_cnt;

  logic pred_valid_q,  pred_valid_d;
  logic pred_taken_q,  pred_taken_d;
  logic pred_strong_q, pred_strong_d;

  function automatic logic [COUNTER_WIDTH-1:0] sat_next(input logic [COUNTER_WIDTH-1:0] cnt,
                                                       input logic                     up);
    if (up) begin
      return (cnt == MAX_C) ? cnt : cnt + 1'b1;
    end
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

  always_comb begin
    upd_cur = table_q[update_index];
    upd_new = sat_next(upd_cur, update_taken);
    rd_cnt  = table_q[lookup_index];
`ifdef BIMODAL_PREDICTOR_BYPASS_EN
    // Forward what the table will hold after this edge so the lookup never sees stale state.
    if (clear) begin
      rd_cnt = RESET_C;
    end else if (update_valid && (update_index == lookup_index)) begin
      rd_cnt = upd_new;
    end
`endif
  end

  always_comb begin
    pred_valid_d  = lookup_valid;
    pred_taken_d  = pred_taken_q;
    pred_strong_d = pred_strong_q;
    if (lookup_valid) begin
      pred_taken_d  = (rd_cnt >= THRESH_C);
      pred_strong_d = (rd_cnt == '0) || (rd_cnt == MAX_C);
    end
  end

  // Clear wins over a same-cycle update, which is simply dropped.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= RESET_C;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= RESET_C;
      end
    end else if (update_valid) begin
      table_q[update_index] <= upd_new;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_strong_q <= 1'b0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_strong_q <= pred_strong_d;
    end
  end

  assign prediction_valid  = pred_valid_q;
  assign prediction_taken  = pred_taken_q;
  assign prediction_strong = pred_strong_q;

endmodule

// File: tb/tb_bimodal_predictor.sv
// Self-checking bench for bimodal_predictor: directed scenarios then random traffic against an array model.
module tb_bimodal_predictor;

  localparam int IW      = 6;
  localparam int RANGE   = 4;
  localparam int RV      = 1;
  localparam int ENTRIES = 1 << IW;

  logic          clock;
  logic          resetn;
  logic          clear;
  logic          lookup_valid;
  logic [IW-1:0] lookup_index;
  logic          prediction_valid;
  logic          prediction_taken;
  logic          prediction_strong;
  logic          update_valid;
  logic [IW-1:0] update_index;
  logic          update_taken;

  bimodal_predictor #(
    .INDEX_WIDTH  (IW),
    .COUNTER_RANGE(RANGE),
    .RESET_VALUE  (RV)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .clear            (clear),
    .lookup_valid     (lookup_valid),
    .lookup_index     (lookup_index),
    .prediction_valid (prediction_valid),
    .prediction_taken (prediction_taken),
    .prediction_strong(prediction_strong),
    .update_valid     (update_valid),
    .update_index     (update_index),
    .update_taken     (update_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int  model [ENTRIES];
  bit  exp_valid;
  bit  exp_taken;
  bit  exp_strong;
  int  total_checks;
  int  passed_checks;
  int  failed_checks;

  task automatic check(input string tag, input logic observed, input logic expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Reference counter behaviour: clamp to [0, RANGE-1].
  function automatic int train(input int value, input bit taken);
    if (taken) return (value + 1 > RANGE - 1) ? RANGE - 1 : value + 1;
    return (value - 1 < 0) ? 0 : value - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model[i] = RV;
  endtask

  // One cycle: drive, predict, advance model, clock, compare. Entered and left #1 after a rising edge.
  task automatic step(input string tag, input bit lv, input int li, input bit uv, input int ui,
                      input bit ut, input bit cl);
    int rd;
    lookup_valid = lv;
    lookup_index = IW'(li);
    update_valid = uv;
    update_index = IW'(ui);
    update_taken = ut;
    clear        = cl;
    rd = model[li];
`ifdef BIMODAL_PREDICTOR_BYPASS_EN
    if (cl) rd = RV;
    else if (uv && ui == li) rd = train(model[ui], ut);
`endif
    exp_valid = lv;
    if (lv) begin
      exp_taken  = (rd >= RANGE / 2);
      exp_strong = (rd == 0) || (rd == RANGE - 1);
    end
    if (cl) model_reset();
    else if (uv) model[ui] = train(model[ui], ut);
    @(posedge clock);
    #1;
    check({tag, ".valid"},  prediction_valid,  exp_valid);
    check({tag, ".taken"},  prediction_taken,  exp_taken);
    check({tag, ".strong"}, prediction_strong, exp_strong);
    $display("%s lv=%0b li=%0d uv=%0b ui=%0d ut=%0b clr=%0b -> v=%0b t=%0b s=%0b", tag, lv, li, uv,
             ui, ut, cl, prediction_valid, prediction_taken, prediction_strong);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    failed_checks = 0;
    exp_valid     = 1'b0;
    exp_taken     = 1'b0;
    exp_strong    = 1'b0;
    model_reset();
    resetn       = 1'b0;
    clear        = 1'b0;
    lookup_valid = 1'b0;
    lookup_index = '0;
    update_valid = 1'b0;
    update_index = '0;
    update_taken = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset.valid",  prediction_valid,  1'b0);
    check("reset.taken",  prediction_taken,  1'b0);
    check("reset.strong", prediction_strong, 1'b0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Reset default read.
    step("rst_lookup5", 1, 5, 0, 0, 0, 0);
    check("rst_lookup5.const_taken",  prediction_taken,  1'b0);
    check("rst_lookup5.const_strong", prediction_strong, 1'b0);

    // Saturate up on index 5.
    for (int k = 0; k < 3; k++) step("sat_up", 0, 0, 1, 5, 1, 0);
    step("sat_up_look", 1, 5, 0, 0, 0, 0);
    check("sat_up.const_taken",  prediction_taken,  1'b1);
    check("sat_up.const_strong", prediction_strong, 1'b1);
    step("sat_up_4th", 0, 0, 1, 5, 1, 0);
    step("sat_up_hold", 1, 5, 0, 0, 0, 0);

    // Saturate down on index 9.
    for (int k = 0; k < 4; k++) step("sat_dn", 0, 0, 1, 9, 0, 0);
    step("sat_dn_look", 1, 9, 0, 0, 0, 0);
    check("sat_dn.const_taken",  prediction_taken,  1'b0);
    check("sat_dn.const_strong", prediction_strong, 1'b1);

    // Hold while no lookup is presented.
    step("hold", 0, 9, 0, 0, 0, 0);

    // Same-cycle collision on index 7.
    step("collide", 1, 7, 1, 7, 1, 0);
`ifdef BIMODAL_PREDICTOR_BYPASS_EN
    check("collide.const_taken", prediction_taken, 1'b1);
`else
    check("collide.const_taken", prediction_taken, 1'b0);
`endif
    step("collide_next", 1, 7, 0, 0, 0, 0);
    check("collide_next.const_taken", prediction_taken, 1'b1);

    // Clear beats a same-cycle update.
    for (int k = 0; k < 3; k++) step("to3", 0, 0, 1, 3, 1, 0);
    step("clear_upd", 1, 3, 1, 3, 1, 1);
    step("after_clear", 1, 3, 0, 0, 0, 0);
    check("after_clear.const_taken",  prediction_taken,  1'b0);
    check("after_clear.const_strong", prediction_strong, 1'b0);
    for (int i = 0; i < ENTRIES; i++) step("clear_sweep", 1, i, 0, 0, 0, 0);

    // Random traffic, narrow index window to force collisions.
    for (int n = 0; n < 1500; n++) begin
      int narrow;
      narrow = $urandom_range(0, 3);
      step("rand", bit'($urandom_range(0, 1)),
           (narrow != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, ENTRIES - 1)),
           bit'($urandom_range(0, 3) != 0),
           (narrow != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, ENTRIES - 1)),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 99) == 0));
    end

    // Async reset between edges with a live prediction.
    step("pre_rst_up", 0, 0, 1, 12, 1, 0);
    step("pre_rst_up", 0, 0, 1, 12, 1, 0);
    step("pre_rst_look", 1, 12, 0, 0, 0, 0);
    check("pre_rst.valid", prediction_valid, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst.valid",  prediction_valid,  1'b0);
    check("async_rst.taken",  prediction_taken,  1'b0);
    check("async_rst.strong", prediction_strong, 1'b0);
    $display("async_rst -> v=%0b t=%0b s=%0b", prediction_valid, prediction_taken,
             prediction_strong);
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    clear        = 1'b0;
    model_reset();
    exp_taken  = 1'b0;
    exp_strong = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < ENTRIES; i++) step("rst_sweep", 1, i, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
